// File: rtl/traffic_ctrl_nway_if.sv
// Purpose : bundles the sensor/emergency inputs and lamp/status outputs of the
//           N-way light controller.
// Ports   : i_sensor_near/i_sensor_far (per-way demand and long-queue sensors),
//           i_emg_req/i_emg_way (preemption request and target way),
//           o_red/o_yellow/o_green (per-way lamps), o_active_way, o_emg_active.
//           master = sensor/stimulus side, slave = controller side.
interface traffic_ctrl_nway_if #(
   parameter int N_WAYS = 4,
   parameter int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) ();
   logic [N_WAYS-1:0] i_sensor_near;
   logic [N_WAYS-1:0] i_sensor_far;
   logic              i_emg_req;
   logic [WAY_W-1:0]  i_emg_way;
   logic [N_WAYS-1:0] o_red;
   logic [N_WAYS-1:0] o_yellow;
   logic [N_WAYS-1:0] o_green;
   logic [WAY_W-1:0]  o_active_way;
   logic              o_emg_active;

   modport master (
      output i_sensor_near, i_sensor_far, i_emg_req, i_emg_way,
      input  o_red, o_yellow, o_green, o_active_way, o_emg_active
   );

   modport slave (
      input  i_sensor_near, i_sensor_far, i_emg_req, i_emg_way,
      output o_red, o_yellow, o_green, o_active_way, o_emg_active
   );
endinterface

// File: rtl/traffic_ctrl_nway.sv
// Purpose : N-way intersection light controller. Demand-driven round-robin
//           service with long/short green, gap-out and emergency preemption.
// Ports   : clk, rst (async active-high), bus (traffic_ctrl_nway_if.slave):
//           sensors and emergency request in, per-way lamps, active way and
//           emergency-active flag out. All outputs are registered; a demand
//           sampled in an IDLE cycle shows as green on the next cycle.
module traffic_ctrl_nway #(
   parameter int N_WAYS   = 4,
   parameter int T_LONG   = 20,
   parameter int T_SHORT  = 8,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 2,
   parameter int CNT_W    = 8
) (
   input logic                clk,
   input logic                rst,
   traffic_ctrl_nway_if.slave bus
);
   localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

   localparam logic [CNT_W-1:0] C_LONG    = CNT_W'(T_LONG);
   localparam logic [CNT_W-1:0] C_SHORT   = CNT_W'(T_SHORT);
   localparam logic [CNT_W-1:0] C_GAP_MIN = CNT_W'(T_SHORT - 1);
   localparam logic [CNT_W-1:0] C_YEL_END = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] C_AR_END  = CNT_W'(T_ALLRED - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GREEN,
      S_YELLOW,
      S_ALLRED
   } state_t;

   state_t            state_q;
   logic [WAY_W-1:0]  active_q;
   logic [WAY_W-1:0]  last_q;
   logic [CNT_W-1:0]  elapsed_q;
   logic [CNT_W-1:0]  target_q;
   logic [N_WAYS-1:0] red_q;
   logic [N_WAYS-1:0] yellow_q;
   logic [N_WAYS-1:0] green_q;
   logic              emg_act_q;

   logic              emg_in_range;
   logic              emg_vld;
   logic              sel_found;
   logic [WAY_W-1:0]  sel_way;
   logic [N_WAYS-1:0] sel_oh;
   logic              select_now;
   logic              near_active;
   logic              green_done;
   logic              gap_out;

   // The range check only matters when N_WAYS is not a power of two;
   // otherwise every encodable way number is a real approach.
   generate
      if ((1 << WAY_W) > N_WAYS) begin : g_emg_chk
         assign emg_in_range = ({1'b0, bus.i_emg_way} < (WAY_W + 1)'(N_WAYS));
      end else begin : g_emg_all
         assign emg_in_range = 1'b1;
      end
   endgenerate

   assign emg_vld = bus.i_emg_req & emg_in_range;

   // Selection happens in every IDLE cycle and on the final ALLRED cycle.
   assign select_now = (state_q == S_IDLE) ||
                       ((state_q == S_ALLRED) && (elapsed_q == C_AR_END));

   // Round-robin search starting at last+1. Walking k downward means the
   // smallest offset with demand is the one that sticks; k == N_WAYS is the
   // last-served way itself, so it naturally has the lowest priority.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_way   = '0;
      idx       = 0;
      if (emg_vld) begin
         sel_found = 1'b1;
         sel_way   = bus.i_emg_way;
      end else begin
         for (int k = N_WAYS; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N_WAYS;
            if (bus.i_sensor_near[idx]) begin
               sel_found = 1'b1;
               sel_way   = WAY_W'(idx);
            end
         end
      end
   end

   always_comb begin
      sel_oh          = '0;
      sel_oh[sel_way] = 1'b1;
   end

   assign near_active = bus.i_sensor_near[active_q];
   assign green_done  = (elapsed_q == target_q - 1'b1);
   assign gap_out     = !near_active && (elapsed_q >= C_GAP_MIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         active_q  <= '0;
         last_q    <= WAY_W'(N_WAYS - 1);
         elapsed_q <= '0;
         target_q  <= C_SHORT;
         red_q     <= '1;
         yellow_q  <= '0;
         green_q   <= '0;
         emg_act_q <= 1'b0;
      end else if (select_now) begin
         if (sel_found) begin
            // Green target is latched here and never revisited mid-green.
            state_q   <= S_GREEN;
            active_q  <= sel_way;
            last_q    <= sel_way;
            elapsed_q <= '0;
            target_q  <= bus.i_sensor_far[sel_way] ? C_LONG : C_SHORT;
            red_q     <= ~sel_oh;
            yellow_q  <= '0;
            green_q   <= sel_oh;
            emg_act_q <= emg_vld;
         end else begin
            state_q   <= S_IDLE;
            elapsed_q <= '0;
            red_q     <= '1;
            yellow_q  <= '0;
            green_q   <= '0;
            emg_act_q <= 1'b0;
         end
      end else begin
         case (state_q)
            S_GREEN: begin
               if (emg_vld && (bus.i_emg_way != active_q)) begin
                  // Preempted by another way: minimum green is not honoured.
                  state_q   <= S_YELLOW;
                  elapsed_q <= '0;
                  yellow_q  <= green_q;
                  green_q   <= '0;
                  emg_act_q <= 1'b0;
               end else if (emg_vld) begin
                  // Serving the emergency way: timer and gap-out frozen.
                  emg_act_q <= 1'b1;
               end else if (green_done || gap_out) begin
                  state_q   <= S_YELLOW;
                  elapsed_q <= '0;
                  yellow_q  <= green_q;
                  green_q   <= '0;
                  emg_act_q <= 1'b0;
               end else begin
                  emg_act_q <= 1'b0;
                  if (elapsed_q < target_q) begin
                     elapsed_q <= elapsed_q + 1'b1;
                  end
               end
            end
            S_YELLOW: begin
               if (elapsed_q == C_YEL_END) begin
                  state_q   <= S_ALLRED;
                  elapsed_q <= '0;
                  red_q     <= '1;
                  yellow_q  <= '0;
               end else begin
                  elapsed_q <= elapsed_q + 1'b1;
               end
            end
            S_ALLRED: begin
               elapsed_q <= elapsed_q + 1'b1;
            end
            default: begin
               state_q   <= S_IDLE;
               elapsed_q <= '0;
               red_q     <= '1;
               yellow_q  <= '0;
               green_q   <= '0;
               emg_act_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_red        = red_q;
   assign bus.o_yellow     = yellow_q;
   assign bus.o_green      = green_q;
   assign bus.o_active_way = active_q;
   assign bus.o_emg_active = emg_act_q;

endmodule
